// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, word field
// positions, FSM state encoding and the assembled-instruction record.
package instr_fetch_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_INPUT = 8'h01;
    localparam logic [7:0] OP_MOV   = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h10;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 8;
    localparam int ARG_MSB = 7;
    localparam int ARG_LSB = 0;

    localparam logic [1:0] FETCH_OP  = 2'd0;
    localparam logic [1:0] FETCH_IMM = 2'd1;
    localparam logic [1:0] HALTED    = 2'd2;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  arg;
        logic [15:0] imm;
        logic [15:0] pc;
    } instr_t;

    function automatic logic [7:0] word_opcode(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [7:0] word_arg(input logic [15:0] word);
        return word[ARG_MSB:ARG_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory bus, control-unit handshake and redirect.
// master = fetch stage, slave = memory/control side.
interface instr_fetch_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_enable;
    logic        mem_write;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_arg;
    logic [15:0] instr_imm;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;

    modport master (
        output mem_addr, mem_enable, mem_write,
        output instr_valid, instr_opcode, instr_arg, instr_imm, instr_pc, halted,
        input  mem_data, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_enable, mem_write,
        input  instr_valid, instr_opcode, instr_arg, instr_imm, instr_pc, halted,
        output mem_data, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_out_reg.sv
// Valid/ready holding register for one assembled instruction.
// Load wins over consume; flush drops the held instruction.
module instr_out_reg
    import instr_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    input  logic   load_i,
    input  logic   ready_i,
    input  instr_t data_i,
    output logic   valid_o,
    output instr_t data_o
);

    logic   valid_q;
    instr_t data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: steps the PC, assembles one/two-word instructions and hands
// them to the control unit. Optional halt support: INSTR_FETCH_HALT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [7:0]  IMM_OPCODE  = OP_INPUT,
    parameter logic [7:0]  HALT_OPCODE = OP_HALT
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    logic [15:0] pc_q, pc_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  pend_op_q, pend_op_d;
    logic [7:0]  pend_arg_q, pend_arg_d;
    logic [15:0] pend_pc_q, pend_pc_d;

    logic        out_valid;
    instr_t      out_data;
    logic        load_en;
    instr_t      load_data;
    logic        can_load;
    logic        mem_en;
    logic [7:0]  word_op;
    logic [7:0]  word_a;

    assign can_load = !out_valid || bus.instr_ready;
    assign mem_en   = !rst && !bus.redirect_valid && can_load &&
                      (state_q == FETCH_OP || state_q == FETCH_IMM);
    assign word_op  = word_opcode(bus.mem_data);
    assign word_a   = word_arg(bus.mem_data);

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        pend_op_d  = pend_op_q;
        pend_arg_d = pend_arg_q;
        pend_pc_d  = pend_pc_q;
        load_en    = 1'b0;
        load_data  = '0;

        if (mem_en) begin
            pc_d = pc_q + 16'd1;
            case (state_q)
                FETCH_OP: begin
                    if (word_op == IMM_OPCODE) begin
                        pend_op_d  = word_op;
                        pend_arg_d = word_a;
                        pend_pc_d  = pc_q;
                        state_d    = FETCH_IMM;
                    end else begin
                        load_en   = 1'b1;
                        load_data = '{opcode: word_op, arg: word_a, imm: 16'h0000, pc: pc_q};
`ifdef INSTR_FETCH_HALT_EN
                        // The halt word itself is still delivered before fetch stops.
                        if (word_op == HALT_OPCODE)
                            state_d = HALTED;
`endif
                    end
                end
                FETCH_IMM: begin
                    load_en   = 1'b1;
                    load_data = '{opcode: pend_op_q, arg: pend_arg_q,
                                  imm: bus.mem_data, pc: pend_pc_q};
                    state_d   = FETCH_OP;
                end
                default: ;
            endcase
        end

        // Redirect abandons any half-assembled immediate instruction and exits HALTED.
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            state_d = FETCH_OP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= FETCH_OP;
            pend_op_q  <= '0;
            pend_arg_q <= '0;
            pend_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            pend_op_q  <= pend_op_d;
            pend_arg_q <= pend_arg_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    instr_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.redirect_valid),
        .load_i  (load_en),
        .ready_i (bus.instr_ready),
        .data_i  (load_data),
        .valid_o (out_valid),
        .data_o  (out_data)
    );

    assign bus.mem_addr     = pc_q;
    assign bus.mem_enable   = mem_en;
    assign bus.mem_write    = 1'b0;
    assign bus.instr_valid  = out_valid;
    assign bus.instr_opcode = out_data.opcode;
    assign bus.instr_arg    = out_data.arg;
    assign bus.instr_imm    = out_data.imm;
    assign bus.instr_pc     = out_data.pc;

`ifdef INSTR_FETCH_HALT_EN
    assign bus.halted = (state_q == HALTED);
`else
    logic unused_halt;
    assign unused_halt = ^HALT_OPCODE;
    assign bus.halted  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory image table, backpressure, redirect, PC wrap,
// reset during stall and (with INSTR_FETCH_HALT_EN) halt/resume.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:65535];
    assign bus.mem_data = mem[bus.mem_addr];

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  arg;
        logic [15:0] imm;
        logic [15:0] pc;
        int          gap;
    } exp_t;

    typedef struct {
        logic [15:0] word;
        bit          has_exp;
        logic [7:0]  op;
        logic [7:0]  arg;
        logic [15:0] imm;
        int          gap;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   last_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted transfer is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && !bus.redirect_valid && bus.instr_valid && bus.instr_ready) begin
            $display("xfer pc=%h op=%h arg=%h imm=%h cyc=%0d",
                     bus.instr_pc, bus.instr_opcode, bus.instr_arg, bus.instr_imm, cyc);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("xfer_fields", {bus.instr_opcode, bus.instr_arg, bus.instr_imm},
                      {mon_e.op, mon_e.arg, mon_e.imm});
                check("xfer_pc", {16'h0, bus.instr_pc}, {16'h0, mon_e.pc});
                if (mon_e.gap != 0)
                    check("xfer_gap", cyc - last_hs, mon_e.gap);
            end
            last_hs <= cyc;
        end
    end

    task automatic push(input logic [7:0] op, input logic [7:0] arg,
                        input logic [15:0] imm, input logic [15:0] pc, input int gap);
        exp_t e;
        e.op = op; e.arg = arg; e.imm = imm; e.pc = pc; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        vecs[0] = '{16'h0000, 1'b1, 8'h00, 8'h00, 16'h0000, 0};
        vecs[1] = '{16'h0236, 1'b1, 8'h02, 8'h36, 16'h0000, 1};
        vecs[2] = '{16'h010B, 1'b1, 8'h01, 8'h0B, 16'h0001, 2};
        vecs[3] = '{16'h0001, 1'b0, 8'h00, 8'h00, 16'h0000, 0};
        vecs[4] = '{16'h010C, 1'b1, 8'h01, 8'h0C, 16'h0001, 2};
        vecs[5] = '{16'h0001, 1'b0, 8'h00, 8'h00, 16'h0000, 0};
        vecs[6] = '{16'h100B, 1'b1, 8'h10, 8'h0B, 16'h0000, 1};

        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        for (int i = 0; i < 7; i++) mem[i] = vecs[i].word;

        rst                = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_mem_en", bus.mem_enable, 0);
        check("rst_fields", {bus.instr_opcode, bus.instr_arg, bus.instr_imm}, 0);
        check("rst_pc", {bus.instr_pc, bus.mem_addr}, 0);
        check("rst_halted_wr", {bus.halted, bus.mem_write}, 0);

        // Memory image, table driven
        for (int i = 0; i < 7; i++)
            if (vecs[i].has_exp)
                push(vecs[i].op, vecs[i].arg, vecs[i].imm, i[15:0], vecs[i].gap);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("first_fetch", {bus.mem_enable, bus.instr_valid, bus.mem_addr}, {1'b1, 1'b0, 16'h0000});
        @(negedge clk);
        check("first_latency", bus.instr_valid, 1);
        wait_empty(30);

        // Backpressure on the 0x0236 instruction
        pulse_reset();
        bus.instr_ready = 1'b1;
        push(8'h00, 8'h00, 16'h0000, 16'h0000, 0);
        push(8'h02, 8'h36, 16'h0000, 16'h0001, 0);
        push(8'h01, 8'h0B, 16'h0001, 16'h0002, 0);
        tick();
        tick();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out", {bus.instr_valid, bus.instr_opcode, bus.instr_arg, bus.instr_pc[6:0]},
                  {1'b1, 8'h02, 8'h36, 7'h01});
            check("stall_mem", {bus.mem_enable, bus.mem_addr}, {1'b0, 16'h0002});
            tick();
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("stall_release", {bus.mem_enable, bus.mem_addr}, {1'b1, 16'h0002});
        wait_empty(20);

        // Redirect while waiting for the immediate word
        pulse_reset();
        push(8'h00, 8'h00, 16'h0000, 16'h0000, 0);
        push(8'h02, 8'h36, 16'h0000, 16'h0001, 0);
        push(8'h10, 8'h0B, 16'h0000, 16'h0006, 0);
        tick();
        tick();
        tick();
        check("redir_pc3", bus.mem_addr, 16'h0003);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0006;
        @(negedge clk);
        check("redir_mem_en", bus.mem_enable, 0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_after", {bus.instr_valid, bus.mem_addr}, {1'b0, 16'h0006});
        wait_empty(20);

        // PC wrap across an immediate instruction
        mem[16'hFFFF] = 16'h010B;
        mem[0]        = 16'h1234;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFF;
        push(8'h01, 8'h0B, 16'h1234, 16'hFFFF, 0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr0", bus.mem_addr, 16'hFFFF);
        tick();
        @(negedge clk);
        check("wrap_addr1", bus.mem_addr, 16'h0000);
        tick();
        @(negedge clk);
        check("wrap_addr2", {bus.instr_valid, bus.mem_addr}, {1'b1, 16'h0001});
        wait_empty(5);
        mem[0] = 16'h0000;

        // Reset while an instruction is held under backpressure
        bus.instr_ready = 1'b0;
        tick();
        tick();
        tick();
        check("rs_held", {bus.instr_valid, bus.mem_enable}, {1'b1, 1'b0});
        pulse_reset();
        @(negedge clk);
        check("rs_cleared", {bus.instr_valid, bus.mem_addr, bus.instr_pc}, {1'b0, 16'h0000, 16'h0000});
        push(8'h00, 8'h00, 16'h0000, 16'h0000, 0);
        push(8'h02, 8'h36, 16'h0000, 16'h0001, 0);
        bus.instr_ready = 1'b1;
        wait_empty(20);

        // Halt opcode at address 7
        mem[7] = 16'hFF00;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0006;
        push(8'h10, 8'h0B, 16'h0000, 16'h0006, 0);
        push(8'hFF, 8'h00, 16'h0000, 16'h0007, 0);
        tick();
        bus.redirect_valid = 1'b0;
        wait_empty(10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef INSTR_FETCH_HALT_EN
            check("halt_hold", {bus.halted, bus.mem_enable}, {1'b1, 1'b0});
`else
            check("halt_none", {bus.halted, bus.mem_enable}, {1'b0, 1'b1});
`endif
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0000;
        @(negedge clk);
        check("resume_redir", bus.mem_enable, 0);
        tick();
        bus.redirect_valid = 1'b0;
        push(8'h00, 8'h00, 16'h0000, 16'h0000, 0);
        @(negedge clk);
        check("resume", {bus.halted, bus.mem_enable, bus.mem_addr}, {1'b0, 1'b1, 16'h0000});
        wait_empty(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
